// File: rtl/keycode_publisher.sv
// -----------------------------------------------------------------------------
// keycode_publisher
//
// Producer end of the 16-bit keycode interface read by the game status FSM.
// USB-host software writes each HID boot-keyboard report (two 8-bit key slots)
// over Avalon-MM. The report is published on keycode[15:0] once it has been
// diffed against the previous report. The diff produces press/release events
// that are queued in a show-ahead FIFO and popped with a valid/ready handshake.
//
// Ports:
//   Clk              system clock
//   Reset_n          asynchronous, active-low reset
//   avl_chipselect   Avalon-MM slave select
//   avl_write        write strobe
//   avl_read         read strobe
//   avl_address[1:0] register address (0 = report, 1 = FIFO status/control)
//   avl_writedata    write data
//   avl_readdata     read data, combinational from address
//   avl_waitrequest  stalls address-0 writes while a diff is in progress
//   keycode[15:0]    published report: [7:0] = slot0, [15:8] = slot1
//   evt_valid        FIFO head valid
//   evt_ready        consumer accepts head
//   evt_data[8:0]    {press(1)/release(0), code[7:0]}
// -----------------------------------------------------------------------------
module keycode_publisher #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        avl_chipselect,
  input  logic        avl_write,
  input  logic        avl_read,
  input  logic [1:0]  avl_address,
  input  logic [31:0] avl_writedata,
  output logic [31:0] avl_readdata,
  output logic        avl_waitrequest,
  output logic [15:0] keycode,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [8:0]  evt_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Diff sequencer states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_R0     = 3'd1;
  localparam logic [2:0] S_R1     = 3'd2;
  localparam logic [2:0] S_P0     = 3'd3;
  localparam logic [2:0] S_P1     = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;

  // HID "ErrorRollOver" code: the keyboard could not report its state
  localparam logic [7:0] KEY_ROLLOVER = 8'h01;

  logic [2:0]  state;
  logic [15:0] new_r;
  logic [15:0] old_r;

  logic [7:0] new0, new1, old0, old1;
  assign new0 = new_r[7:0];
  assign new1 = new_r[15:8];
  assign old0 = old_r[7:0];
  assign old1 = old_r[15:8];

  // ---------------------------------------------------------------------------
  // Avalon-MM decode
  // ---------------------------------------------------------------------------
  logic wr_req;
  logic addr0_wr_acc;
  logic addr1_wr;
  logic clr_ovf;
  logic flush;

  assign wr_req          = avl_chipselect & avl_write;
  assign avl_waitrequest = wr_req & (avl_address == 2'd0) & (state != S_IDLE);
  assign addr0_wr_acc    = wr_req & (avl_address == 2'd0) & ~avl_waitrequest;
  // Status/control writes are never stalled, even mid-diff.
  assign addr1_wr        = wr_req & (avl_address == 2'd1);
  assign clr_ovf         = addr1_wr & avl_writedata[0];
  assign flush           = addr1_wr & avl_writedata[1];

  // Upper write-data bits carry no register content.
  logic unused_wdata;
  assign unused_wdata = ^avl_writedata[31:16];

  // ---------------------------------------------------------------------------
  // Event generation: one candidate event per diff state
  // ---------------------------------------------------------------------------
  logic       push_req;
  logic [8:0] push_data;

  // NOTE: every output of a combinational block gets a default up front so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    push_req  = 1'b0;
    push_data = '0;
    case (state)
      S_R0: begin
        push_req  = (old0 != 8'h00) && (old0 != new0) && (old0 != new1);
        push_data = {1'b0, old0};
      end
      S_R1: begin
        // A code held in both old slots is released only once (from slot0).
        push_req  = (old1 != 8'h00) && (old1 != old0) &&
                    (old1 != new0) && (old1 != new1);
        push_data = {1'b0, old1};
      end
      S_P0: begin
        push_req  = (new0 != 8'h00) && (new0 != old0) && (new0 != old1);
        push_data = {1'b1, new0};
      end
      S_P1: begin
        push_req  = (new1 != 8'h00) && (new1 != new0) &&
                    (new1 != old0) && (new1 != old1);
        push_data = {1'b1, new1};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Diff sequencer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its inputs as they stood before the clock edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      new_r   <= '0;
      old_r   <= '0;
      keycode <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (addr0_wr_acc) begin
            new_r <= avl_writedata[15:0];
            old_r <= keycode;
            // A rollover report says nothing about which keys are down; drop it.
            if (avl_writedata[7:0] != KEY_ROLLOVER &&
                avl_writedata[15:8] != KEY_ROLLOVER)
              state <= S_R0;
          end
        end
        S_R0:     state <= S_R1;
        S_R1:     state <= S_P0;
        S_P0:     state <= S_P1;
        S_P1:     state <= S_COMMIT;
        S_COMMIT: begin
          // Publishing last guarantees all events of this report are queued
          // before the consumer can observe the new keycode.
          keycode <= new_r;
          state   <= S_IDLE;
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic full;
  logic pop;
  logic do_push;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign pop       = evt_valid & evt_ready;
  // When full, a simultaneous pop frees the slot the push needs.
  assign do_push   = push_req & ~flush & (~full | pop);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
      // A drop is evidence worth keeping, so it beats a same-cycle clear.
      if (push_req && !flush && full && !pop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked by
  // the reset pointers/count, and stale entries are never presented.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign evt_data = evt_valid ? mem[rd_ptr] : '0;

  // ---------------------------------------------------------------------------
  // Read mux (zero wait states)
  // ---------------------------------------------------------------------------
  always_comb begin
    avl_readdata = '0;
    if (avl_chipselect && avl_read) begin
      case (avl_address)
        2'd0: avl_readdata[15:0] = keycode;
        2'd1: begin
          avl_readdata[8]       = overflow;
          avl_readdata[CNT_W-1:0] = count;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keycode_publisher.sv
// -----------------------------------------------------------------------------
// tb_keycode_publisher
//
// Scoreboard bench for keycode_publisher. The reference model treats each
// report as a set of held keys: releases are old keys missing from the new
// report, presses are new keys missing from the old one, each in slot order.
// Expected events are queued when a report is issued; an independent monitor
// pops and compares on every evt_valid/evt_ready handshake.
// -----------------------------------------------------------------------------
module tb_keycode_publisher;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        avl_chipselect = 1'b0;
  logic        avl_write = 1'b0;
  logic        avl_read = 1'b0;
  logic [1:0]  avl_address = 2'd0;
  logic [31:0] avl_writedata = '0;
  logic [31:0] avl_readdata;
  logic        avl_waitrequest;
  logic [15:0] keycode;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [8:0]  evt_data;

  keycode_publisher #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .avl_chipselect  (avl_chipselect),
    .avl_write       (avl_write),
    .avl_read        (avl_read),
    .avl_address     (avl_address),
    .avl_writedata   (avl_writedata),
    .avl_readdata    (avl_readdata),
    .avl_waitrequest (avl_waitrequest),
    .keycode         (keycode),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_data        (evt_data)
  );

  initial forever #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  logic [8:0]  exp_q[$];
  logic [15:0] model_kc = 16'h0000;
  bit          use_cap = 1'b0;  // consumer stalled: queue length equals FIFO occupancy
  int          ready_cfg = 1;   // 0 = hold low, 1 = hold high, 2 = random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit held(input logic [7:0] code, input logic [15:0] rep);
    return (code == rep[7:0]) || (code == rep[15:8]);
  endfunction

  function automatic void add_exp(input logic [8:0] e);
    if (!use_cap || exp_q.size() < FIFO_DEPTH) exp_q.push_back(e);
  endfunction

  function automatic void model_report(input logic [15:0] nr);
    logic [7:0] c;
    if (nr[7:0] == 8'h01 || nr[15:8] == 8'h01) return;
    for (int i = 0; i < 2; i++) begin
      c = model_kc[8*i +: 8];
      if (c != 8'h00 && !held(c, nr) && !(i == 1 && c == model_kc[7:0]))
        add_exp({1'b0, c});
    end
    for (int i = 0; i < 2; i++) begin
      c = nr[8*i +: 8];
      if (c != 8'h00 && !held(c, model_kc) && !(i == 1 && c == nr[7:0]))
        add_exp({1'b1, c});
    end
    model_kc = nr;
  endfunction

  // ---------------------------------------------------------------------------
  // Consumer ready driver and monitor
  // ---------------------------------------------------------------------------
  initial forever begin
    @(posedge Clk); #1;
    case (ready_cfg)
      0:       evt_ready = 1'b0;
      1:       evt_ready = 1'b1;
      default: evt_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  initial forever begin
    @(negedge Clk);
    if (Reset_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL evt_unexpected: got 0x%0h, expected no event", evt_data);
      end else begin
        check("evt", {23'b0, evt_data}, {23'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Bus tasks
  // ---------------------------------------------------------------------------
  task automatic avl_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge Clk); #1;
    avl_chipselect = 1'b1; avl_write = 1'b1; avl_address = a; avl_writedata = d;
    for (int n = 0; n < 60; n++) begin
      @(negedge Clk);
      if (!avl_waitrequest) break;
      if (n == 59) begin
        tests++; fails++;
        $display("FAIL wr_accept_timeout: got waitrequest=1, expected 0 within 60 cycles");
      end
    end
    @(posedge Clk); #1;
    avl_chipselect = 1'b0; avl_write = 1'b0;
  endtask

  task automatic avl_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge Clk); #1;
    avl_chipselect = 1'b1; avl_read = 1'b1; avl_address = a;
    @(negedge Clk);
    d = avl_readdata;
    @(posedge Clk); #1;
    avl_chipselect = 1'b0; avl_read = 1'b0;
  endtask

  // Wait out a full diff, then compare the published keycode with the model.
  task automatic settle_kc(input string name);
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    check(name, {16'b0, keycode}, {16'b0, model_kc});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] pool [6] = '{8'h00, 8'h00, 8'h04, 8'h05, 8'h1A, 8'h28};
    if ($urandom_range(0, 15) == 0) return 8'h01;
    return pool[$urandom_range(0, 5)];
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    logic [15:0] kc_at;
    logic [15:0] rep;
    int stalls;

    // Reset state
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(negedge Clk);
    check("rst_keycode", {16'b0, keycode}, 0);
    check("rst_evt_valid", {31'b0, evt_valid}, 0);
    check("rst_evt_data", {23'b0, evt_data}, 0);
    check("rst_waitreq", {31'b0, avl_waitrequest}, 0);
    avl_rd(2'd1, rd);
    check("rst_status", rd, 0);

    // First report: latency and stall of a back-to-back write
    model_report(16'h0028);
    avl_wr(2'd0, 32'h0000_0028);
    check("kc_at_accept", {16'b0, keycode}, 0);
    model_report(16'h0028);
    avl_chipselect = 1'b1; avl_write = 1'b1; avl_address = 2'd0; avl_writedata = 32'h0028;
    stalls = 0;
    kc_at = 16'hFFFF;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      if (!avl_waitrequest) break;
      stalls++;
      kc_at = keycode;
    end
    check("stall_cycles", stalls, 5);
    check("kc_before_commit", {16'b0, kc_at}, 0);
    check("kc_after_commit", {16'b0, keycode}, 32'h0028);
    @(posedge Clk); #1;
    avl_chipselect = 1'b0; avl_write = 1'b0;
    settle_kc("kc_0028");
    drain("drain_0028");

    // Release before presses, slot0 before slot1
    model_report(16'h1A04);
    avl_wr(2'd0, 32'h0000_1A04);
    settle_kc("kc_1a04");
    avl_rd(2'd0, rd);
    check("rd_addr0", rd, 32'h0000_1A04);
    drain("drain_1a04");

    // Duplicate slots, then a rollover report that must be discarded
    avl_wr(2'd0, 32'h0000_0000);
    model_report(16'h0000);
    settle_kc("kc_zero");
    model_report(16'h0404);
    avl_wr(2'd0, 32'h0000_0404);
    settle_kc("kc_0404");
    model_report(16'h0101);
    avl_wr(2'd0, 32'h0000_0101);
    settle_kc("kc_rollover_kept");
    drain("drain_0404");

    // Overflow with the consumer stalled
    model_report(16'h0000);
    avl_wr(2'd0, 32'h0000_0000);
    settle_kc("kc_zero2");
    drain("drain_pre_ovf");
    ready_cfg = 0;
    repeat (2) @(posedge Clk);
    use_cap = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rep = (i % 2 == 0) ? 16'h0028 : 16'h0000;
      model_report(rep);
      avl_wr(2'd0, {16'b0, rep});
    end
    settle_kc("kc_ovf_seq");
    avl_rd(2'd1, rd);
    check("status_full_ovf", rd, 32'h0000_0108);
    check("head_when_full", {23'b0, evt_data}, 32'h0000_0128);
    avl_wr(2'd1, 32'h1);
    avl_rd(2'd1, rd);
    check("status_ovf_cleared", rd, 32'h0000_0008);
    avl_wr(2'd1, 32'h2);
    exp_q.delete();
    use_cap = 1'b0;
    @(negedge Clk);
    check("flush_evt_valid", {31'b0, evt_valid}, 0);
    avl_rd(2'd1, rd);
    check("status_flushed", rd, 0);

    // Reset during P0 aborts the diff and drops its queued release
    avl_wr(2'd0, 32'h0000_0504);
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    exp_q.delete();
    model_kc = 16'h0000;
    @(negedge Clk);
    check("abort_keycode", {16'b0, keycode}, 0);
    check("abort_evt_valid", {31'b0, evt_valid}, 0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    ready_cfg = 1;
    model_report(16'h0005);
    avl_wr(2'd0, 32'h0000_0005);
    settle_kc("kc_after_abort");
    drain("drain_after_abort");

    // Randomized reports with a randomly stalling consumer
    ready_cfg = 2;
    for (int i = 0; i < 60; i++) begin
      for (int n = 0; n < 300 && exp_q.size() > FIFO_DEPTH - 4; n++) @(negedge Clk);
      rep = {rand_code(), rand_code()};
      model_report(rep);
      avl_wr(2'd0, {16'b0, rep});
      if ($urandom_range(0, 1) == 1) settle_kc("kc_random");
    end
    settle_kc("kc_random_final");

    // Drain and confirm nothing was lost or dropped
    ready_cfg = 1;
    drain("drain_final");
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("final_evt_valid", {31'b0, evt_valid}, 0);
    avl_rd(2'd1, rd);
    check("final_status", rd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
